// File: rtl/ahb_defs.sv
// Shared AHB encodings and arbiter state type for the arbiter and master-side logic.
package ahb_defs;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_BURST  = 2'd2,
    ST_LOCKED = 2'd3
  } arb_state_e;

  // Beats still to come after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin selector: first requester after ptr_i wins (ptr_i itself last).
// Returns a one-hot winner, all-zero when nobody requests.
module ahb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_o
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-burst tracking, locked transfers and ERROR recovery.
// Grant is registered; HMASTER/HMASTLOCK follow the grant one ready cycle later.
module ahb_arbiter
  import ahb_defs::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   ahb_clk_in,
  input  logic                   ahb_rstn_in,
  input  logic [NUM_MASTERS-1:0] mst_req_in,
  input  logic [NUM_MASTERS-1:0] mst_lock_in,
  input  logic [1:0]             ahb_trans_in,
  input  logic [2:0]             ahb_burst_in,
  input  logic                   ahb_ready_in,
  input  logic                   ahb_resp_in,
  output logic [NUM_MASTERS-1:0] mst_grant_out,
  output logic [MW-1:0]          ahb_master_out,
  output logic                   ahb_mastlock_out
);

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  arb_state_e       state_q, state_d;
  // The granted index doubles as the round-robin pointer (last granted master).
  logic [MW-1:0]    gidx_q, gidx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [MW-1:0]    master_q, master_d;
  logic             mastlock_q, mastlock_d;
  logic             err_q, err_d;

  logic [NUM_MASTERS-1:0] win;
  logic [MW-1:0]          win_idx;
  logic [3:0]             beats;
  logic                   own_lock;
  logic                   arb_pt;

  ahb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (MW)
  ) u_pick (
    .req_i (mst_req_in),
    .ptr_i (gidx_q),
    .win_o (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win[i]) win_idx = MW'(i);
    end
  end

  assign beats = burst_beats(ahb_burst_in);

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    cnt_d      = cnt_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    err_d      = err_q;
    arb_pt     = 1'b0;
    own_lock   = mst_lock_in[gidx_q];

    if (!ahb_ready_in) begin
      // First ERROR cycle: drop burst tracking and force arbitration on the next ready.
      if (ahb_resp_in && state_q != ST_LOCKED) begin
        cnt_d = 4'd0;
        err_d = 1'b1;
      end
    end else begin
      master_d   = gidx_q;
      mastlock_d = own_lock;
      err_d      = 1'b0;

      unique case (state_q)
        ST_IDLE, ST_OWNED: begin
          if (!err_q && ahb_trans_in == HTRANS_NONSEQ && beats != 4'd0) begin
            state_d = ST_BURST;
            cnt_d   = beats;
          end else begin
            cnt_d  = 4'd0;
            arb_pt = 1'b1;
          end
        end
        ST_BURST: begin
          if (err_q) begin
            arb_pt = 1'b1;
          end else begin
            case (ahb_trans_in)
              HTRANS_SEQ: begin
                if (cnt_q == 4'd1) begin
                  cnt_d  = 4'd0;
                  arb_pt = 1'b1;
                end else begin
                  cnt_d = cnt_q - 4'd1;
                end
              end
              HTRANS_IDLE: begin
                cnt_d   = 4'd0;
                state_d = ST_OWNED;
              end
              HTRANS_NONSEQ: begin
                cnt_d = beats;
                if (beats == 4'd0) state_d = ST_OWNED;
              end
              default: ;
            endcase
          end
        end
        ST_LOCKED: begin
          // Unlock only returns to OWNED; the handover happens on the following cycle.
          if (!own_lock) state_d = ST_OWNED;
        end
      endcase

      if (arb_pt) begin
        if (own_lock) begin
          state_d = ST_LOCKED;
        end else if (|mst_req_in) begin
          gidx_d  = win_idx;
          state_d = ST_OWNED;
        end else begin
          gidx_d  = DEF_IDX;
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      state_q    <= ST_IDLE;
      gidx_q     <= DEF_IDX;
      cnt_q      <= 4'd0;
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      cnt_q      <= cnt_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      err_q      <= err_d;
    end
  end

  assign mst_grant_out    = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << gidx_q;
  assign ahb_master_out   = master_q;
  assign ahb_mastlock_out = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_ahb_arbiter;
  import ahb_defs::*;

  localparam int K_GRANT  = 0;
  localparam int K_MASTER = 1;
  localparam int K_MLOCK  = 2;
  localparam int K_STATE  = 3;
  localparam int K_CNT    = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req, lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready, resp;
  logic [3:0] grant;
  logic [1:0] master;
  logic       mastlock;

  int   cyc_cnt = 0;
  int   tests   = 0;
  int   fails   = 0;
  bit   onehot_en = 1'b0;
  exp_t expq[$];
  exp_t mon_e;
  logic [3:0] act;

  logic [3:0] rr_grant [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] rr_mst   [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .ahb_clk_in       (clk),
    .ahb_rstn_in      (rstn),
    .mst_req_in       (req),
    .mst_lock_in      (lock),
    .ahb_trans_in     (trans),
    .ahb_burst_in     (burst),
    .ahb_ready_in     (ready),
    .ahb_resp_in      (resp),
    .mst_grant_out    (grant),
    .ahb_master_out   (master),
    .ahb_mastlock_out (mastlock)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [3:0] actual(input int kind);
    case (kind)
      K_GRANT:  return grant;
      K_MASTER: return {2'b00, master};
      K_MLOCK:  return {3'b000, mastlock};
      K_STATE:  return {2'b00, dut.state_q};
      default:  return dut.cnt_q;
    endcase
  endfunction

  // Expectation for the outputs seen after the next rising edge.
  task automatic chk(input int kind, input logic [3:0] val, input string tag);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    expq.push_back(e);
  endtask

  task automatic drv(input logic [3:0] r, input logic [3:0] l, input logic [1:0] t,
                     input logic [2:0] b, input logic rdy, input logic rsp);
    req = r; lock = l; trans = t; burst = b; ready = rdy; resp = rsp;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (onehot_en) begin
      tests++;
      if (!$onehot(grant)) begin
        fails++;
        $display("FAIL onehot_grant (cycle %0d): got %b, expected exactly one bit set", cyc_cnt, grant);
      end
    end
    while (expq.size() > 0 && expq[0].cyc <= cyc_cnt) begin
      mon_e = expq.pop_front();
      tests++;
      act = actual(mon_e.kind);
      if (mon_e.cyc != cyc_cnt) begin
        fails++;
        $display("FAIL %s: sample for cycle %0d missed (now %0d)", mon_e.tag, mon_e.cyc, cyc_cnt);
      end else if (act !== mon_e.val) begin
        fails++;
        $display("FAIL %s (cycle %0d): got %0h, expected %0h", mon_e.tag, cyc_cnt, act, mon_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    drv(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    step();
    chk(K_GRANT,  4'b0001, "rst_grant");
    chk(K_MASTER, 4'd0,    "rst_master");
    chk(K_MLOCK,  4'd0,    "rst_mastlock");
    chk(K_STATE,  4'(ST_IDLE), "rst_state");
    chk(K_CNT,    4'd0,    "rst_cnt");
    step();
    onehot_en = 1'b1;
    rstn = 1'b1;

    // All four request SINGLE transfers: grant rotates every ready cycle.
    drv(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk(K_GRANT,  rr_grant[k], "rr_grant");
      chk(K_MASTER, rr_mst[k],   "rr_master");
      step();
    end

    // Pending request while ready is low: nothing moves until ready returns.
    drv(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk(K_GRANT,  4'b0010, "stall_grant");
      chk(K_MASTER, 4'd0,    "stall_master");
      step();
    end
    drv(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_GRANT,  4'b0100, "stall_release_grant");
    chk(K_MASTER, 4'd1,    "stall_release_master");
    step();
    chk(K_MASTER, 4'd2,    "stall_master_follow");
    step();

    // Master 1 INCR4 with master 2 waiting: handover on the last address phase.
    drv(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_GRANT, 4'b0010, "incr4_setup_grant");
    step();
    chk(K_MASTER, 4'd1, "incr4_setup_master");
    step();
    drv(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, 1'b0);
    chk(K_STATE, 4'(ST_BURST), "incr4_state");
    chk(K_CNT,   4'd3,         "incr4_cnt_load");
    chk(K_GRANT, 4'b0010,      "incr4_grant_hold0");
    step();
    drv(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, 1'b0);
    chk(K_CNT, 4'd2, "incr4_cnt2");
    step();
    chk(K_CNT,   4'd1,    "incr4_cnt1");
    chk(K_GRANT, 4'b0010, "incr4_grant_hold1");
    step();
    chk(K_GRANT,  4'b0100, "incr4_handover_grant");
    chk(K_CNT,    4'd0,    "incr4_cnt_done");
    chk(K_MASTER, 4'd1,    "incr4_master_still1");
    step();
    drv(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_MASTER, 4'd2,    "incr4_master_next");
    chk(K_GRANT,  4'b0100, "incr4_grant_kept");
    step();

    // WRAP16 by master 2, ERROR on beat 2: counter clears, next requester wins on the ready cycle.
    drv(4'b0101, 4'b0000, HTRANS_NONSEQ, HBURST_WRAP16, 1'b1, 1'b0);
    chk(K_CNT,   4'd15,        "wrap16_cnt_load");
    chk(K_STATE, 4'(ST_BURST), "wrap16_state");
    step();
    drv(4'b0101, 4'b0000, HTRANS_SEQ, HBURST_WRAP16, 1'b1, 1'b0);
    chk(K_CNT, 4'd14, "wrap16_beat2");
    step();
    drv(4'b0101, 4'b0000, HTRANS_SEQ, HBURST_WRAP16, 1'b0, 1'b1);
    chk(K_CNT,   4'd0,    "err_cnt_clear");
    chk(K_GRANT, 4'b0100, "err_grant_hold");
    step();
    drv(4'b0101, 4'b0000, HTRANS_IDLE, HBURST_WRAP16, 1'b1, 1'b1);
    chk(K_GRANT, 4'b0001,      "err_regrant");
    chk(K_STATE, 4'(ST_OWNED), "err_state");
    step();
    drv(4'b0001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_MASTER, 4'd0, "err_master_follow");
    step();

    // Master 3 locked while master 0 keeps requesting.
    drv(4'b1000, 4'b1000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_GRANT, 4'b1000, "lock_grant");
    step();
    drv(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk(K_GRANT, 4'b1000, "lock_grant_hold");
      chk(K_MLOCK, 4'd1,    "lock_mastlock");
      if (k == 0) begin
        chk(K_STATE,  4'(ST_LOCKED), "lock_state");
        chk(K_MASTER, 4'd3,          "lock_master");
      end
      step();
    end
    drv(4'b0001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_GRANT, 4'b1000,      "unlock_no_same_cycle_handover");
    chk(K_MLOCK, 4'd0,         "unlock_mastlock");
    chk(K_STATE, 4'(ST_OWNED), "unlock_state");
    step();
    chk(K_GRANT, 4'b0001, "unlock_regrant");
    step();
    chk(K_MASTER, 4'd0, "unlock_master");
    step();

    // Master 0 INCR4 with BUSY and its request dropped: all beats still complete.
    drv(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, 1'b0);
    chk(K_CNT, 4'd3, "drop_cnt_load");
    step();
    drv(4'b0010, 4'b0000, HTRANS_BUSY, HBURST_INCR4, 1'b1, 1'b0);
    chk(K_CNT,   4'd3,    "busy_hold");
    chk(K_GRANT, 4'b0001, "drop_grant_hold0");
    step();
    drv(4'b0010, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, 1'b0);
    chk(K_CNT, 4'd2, "drop_cnt2");
    step();
    chk(K_CNT,   4'd1,    "drop_cnt1");
    chk(K_GRANT, 4'b0001, "drop_grant_hold1");
    step();
    chk(K_GRANT, 4'b0010, "drop_regrant");
    step();

    // Early termination of a WRAP8 by master 1.
    drv(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_MASTER, 4'd1, "early_setup_master");
    step();
    drv(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_WRAP8, 1'b1, 1'b0);
    chk(K_CNT, 4'd7, "early_cnt_load");
    step();
    drv(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_WRAP8, 1'b1, 1'b0);
    chk(K_CNT, 4'd6, "early_cnt6");
    step();
    drv(4'b0011, 4'b0000, HTRANS_IDLE, HBURST_WRAP8, 1'b1, 1'b0);
    chk(K_CNT,   4'd0,         "early_cnt_clear");
    chk(K_STATE, 4'(ST_OWNED), "early_state");
    chk(K_GRANT, 4'b0010,      "early_grant_hold");
    step();
    chk(K_GRANT, 4'b0001, "early_regrant");
    step();

    // Reset in the middle of an INCR8 owned by master 2.
    drv(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_GRANT, 4'b0100, "midrst_setup_grant");
    step();
    chk(K_MASTER, 4'd2, "midrst_setup_master");
    step();
    drv(4'b0100, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, 1'b0);
    chk(K_CNT, 4'd7, "incr8_cnt_load");
    step();
    drv(4'b0100, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, 1'b0);
    step();
    chk(K_CNT,   4'd5,         "incr8_cnt_beat3");
    chk(K_STATE, 4'(ST_BURST), "incr8_state");
    step();
    rstn = 1'b0;
    chk(K_GRANT,  4'b0001,     "midrst_grant");
    chk(K_MASTER, 4'd0,        "midrst_master");
    chk(K_MLOCK,  4'd0,        "midrst_mastlock");
    chk(K_STATE,  4'(ST_IDLE), "midrst_state");
    chk(K_CNT,    4'd0,        "midrst_cnt");
    step();
    rstn = 1'b1;
    drv(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
    chk(K_GRANT,  4'b0001,     "postrst_grant");
    chk(K_MASTER, 4'd0,        "postrst_master");
    chk(K_MLOCK,  4'd0,        "postrst_mastlock");
    chk(K_STATE,  4'(ST_IDLE), "postrst_state");
    chk(K_CNT,    4'd0,        "postrst_cnt");
    step();

    for (int k = 0; k < 20 && expq.size() > 0; k++) step();
    while (expq.size() > 0) begin
      mon_e = expq.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: expectation for cycle %0d never checked", mon_e.tag, mon_e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 4, giving the number of requesting masters (2..8).
REQ-002 The block SHALL have parameter DEFAULT_MASTER, default 0, giving the index granted when no master requests.
REQ-003 ahb_clk_in  input  1  the single clock; all logic SHALL sample on its rising edge.
REQ-004 ahb_rstn_in  input  1  reset, synchronous and active-low.
REQ-005 mst_req_in  input  NUM_MASTERS  per-master bus request (HBUSREQx).
REQ-006 mst_lock_in  input  NUM_MASTERS  per-master locked-transfer request (HLOCKx).
REQ-007 ahb_trans_in  input  2  HTRANS of the current address-phase owner.
REQ-008 ahb_burst_in  input  3  HBURST of the current address-phase owner.
REQ-009 ahb_ready_in  input  1  HREADY.
REQ-010 ahb_resp_in  input  1  HRESP, where 1 means ERROR.
REQ-011 mst_grant_out  output  NUM_MASTERS  one-hot HGRANTx.
REQ-012 ahb_master_out  output  clog2(NUM_MASTERS)  HMASTER, the address-phase owner index.
REQ-013 ahb_mastlock_out  output  1  HMASTLOCK.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE (no request, default master granted), OWNED (single/INCR transfer in progress), BURST (fixed-length burst in progress) and LOCKED.
REQ-015 mst_grant_out SHALL be exactly one-hot in every cycle after reset.
REQ-016 Arbitration SHALL be round-robin: the search starts at the index after the last granted master, and the first requesting master wins.
REQ-017 When no master requests, the grant SHALL move to DEFAULT_MASTER and the state SHALL be IDLE.
REQ-018 The grant SHALL change only in a cycle where ahb_ready_in=1 and the arbitration point (REQ-019..021) is reached.
REQ-019 In IDLE or OWNED, the arbitration point SHALL be any cycle.
REQ-020 On NONSEQ with ready and burst WRAP4/INCR4, WRAP8/INCR8 or WRAP16/INCR16, the block SHALL load a 4-bit beat counter with 3, 7 or 15 respectively and enter BURST.
REQ-021 In BURST, the counter SHALL decrement on each SEQ with ready; on BUSY it SHALL hold; the arbitration point SHALL be when the counter equals 1 and a SEQ is accepted, so the new grant aligns with the last address phase.
REQ-022 On NONSEQ with burst SINGLE or INCR, the state SHALL be OWNED and the counter SHALL stay at 0.
REQ-023 ahb_master_out SHALL update to the granted index one cycle after a grant change, and only in a cycle with ahb_ready_in=1; while ready=0 it SHALL hold.
REQ-024 If the granted master has mst_lock_in=1 at an arbitration point, the block SHALL enter LOCKED and keep the grant regardless of other requests.
REQ-025 ahb_mastlock_out SHALL equal the registered lock of the address-phase owner, updated together with ahb_master_out.
REQ-026 The block SHALL leave LOCKED when the owner deasserts its lock with ready=1; it SHALL then rearbitrate in the next cycle, with no lock-to-unlock handover in the same cycle.
REQ-027 When ahb_resp_in=1 with ready=0 (first ERROR cycle), the counter SHALL clear and the block SHALL treat the next ready cycle as an arbitration point, except in LOCKED.
REQ-028 If the granted master drops its request in BURST, the block SHALL still complete the counted beats before regranting.
REQ-029 If the request and the arbitration point occur in the same cycle, the new request SHALL be eligible.
REQ-030 An IDLE transfer in BURST SHALL clear the counter and return the block to OWNED; this is early termination.

Reset
REQ-031 While ahb_rstn_in=0 at a clock edge, the block SHALL set state=IDLE, mst_grant_out = one-hot DEFAULT_MASTER, ahb_master_out=DEFAULT_MASTER, ahb_mastlock_out=0, counter=0 and the round-robin pointer=DEFAULT_MASTER.
REQ-032 Reset asserted mid-burst or mid-lock SHALL override all state in that edge; no partial burst tracking SHALL survive.

Structure
REQ-033 The HTRANS/HBURST localparam encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3; SINGLE=0 … INCR16=7) SHALL live in a shared ahb_defs package/include used by the master interface and the arbiter.
REQ-034 The round-robin selector SHALL be one sub-module, ahb_rr_pick, taking a request vector and a pointer and returning a one-hot winner; it SHALL be purely combinational.

Verification
REQ-035 The bench SHALL drive reset mid-INCR8 after 3 beats, then release -> on the next cycle grant=0001, master=0, mastlock=0 and state IDLE.
REQ-036 The bench SHALL have masters 1 and 2 request while master 1 does an INCR4 (NONSEQ + 3 SEQ, ready=1) -> grant moves to master 2 in the cycle of the 4th address phase, and ahb_master_out=2 one cycle later.
REQ-037 The bench SHALL have all four masters request continuously with SINGLE transfers -> grant order 1,2,3,0,1 with one grant per ready cycle.
REQ-038 The bench SHALL drive master 3 locked with master 0 requesting for 10 cycles -> grant stays 1000 with mastlock=1; after the lock drops, grant goes to master 0 one cycle later.
REQ-039 The bench SHALL drive an ERROR response (resp=1, ready=0, then resp=1, ready=1) on beat 2 of a WRAP16 -> the counter clears and the grant moves to the next requester in that ready cycle.
REQ-040 The bench SHALL hold ready=0 for 5 cycles at an arbitration point with a pending request -> grant and master remain unchanged until ready=1.
